hilo_muldiv_unit: RTL



---
 rtl/hilo_pkg.sv | 22 ++
 rtl/mul_iter_core.sv | 48 ++++
 rtl/hilo_muldiv_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/accumulate unit: op codes, FSM states
// and the iteration count of the shift-add core.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MSUB  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int ITER_COUNT = 32;

endpackage

// File: rtl/mul_iter_core.sv
// Unsigned shift-add multiplier: one iteration per step, with the multiplier
// held in the low half of the product register and shifted out LSB first.
module mul_iter_core #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               last_iter_o
);

  localparam int CW = $clog2(ITER + 1);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     sum;

  // The add carry becomes the new MSB after the right shift.
  always_comb begin
    sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    prod_d = prod_q[0] ? {sum, prod_q[WIDTH-1:1]} : {1'b0, prod_q[2*WIDTH-1:1]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      mcand_q <= mcand_i;
      prod_q  <= {{WIDTH{1'b0}}, mplier_i};
      cnt_q   <= '0;
    end else if (step_i) begin
      prod_q  <= prod_d;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  assign product_o   = prod_q;
  assign last_iter_o = (cnt_q == CW'(ITER - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/accumulate engine owning HI/LO. Start is accepted only
// in IDLE; Cancel aborts an in-flight multiply without touching HI/LO.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cancel,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output state_e           DbgState
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             sign_q, sign_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic               load, step, last_iter, is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] product, signed_prod, acc;

  assign is_signed   = (Op != 3'(OP_MULTU));
  assign a_mag       = (is_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign b_mag       = (is_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
  assign signed_prod = sign_q ? (~product + 1'b1) : product;
  assign acc         = {hi_q, lo_q};

  mul_iter_core #(.WIDTH(WIDTH), .ITER(ITER)) u_core (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .load_i      (load),
    .step_i      (step),
    .mcand_i     (a_mag),
    .mplier_i    (b_mag),
    .product_o   (product),
    .last_iter_o (last_iter)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sign_d  = sign_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        // Cancel in the same cycle drops the request entirely.
        if (Start && !Cancel) begin
          case (Op)
            3'(OP_MULT), 3'(OP_MULTU), 3'(OP_MADD), 3'(OP_MSUB): begin
              load    = 1'b1;
              op_d    = op_e'(Op);
              sign_d  = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
              state_d = MUL;
            end
            3'(OP_MTHI): begin
              hi_d   = A;
              done_d = 1'b1;
            end
            3'(OP_MTLO): begin
              lo_d   = A;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        if (Cancel) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (last_iter) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!Cancel) begin
          done_d = 1'b1;
          case (op_q)
            OP_MADD: {hi_d, lo_d} = acc + signed_prod;
            OP_MSUB: {hi_d, lo_d} = acc - signed_prod;
            default: {hi_d, lo_d} = signed_prod;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      sign_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy     = (state_q != IDLE);
  assign Done     = done_q;
  assign HiOut    = hi_q;
  assign LoOut    = lo_q;
  assign DbgState = state_q;

endmodule
